filter_mac_kxk: RTL
===================

# filter_mac_kxk

Parametrised, pipelined K×K convolution multiply-accumulate for the image-filter datapath. Each accepted window of K×K signed pixels is multiplied element-wise by a K×K signed coefficient set and summed. The sum is rounded, shifted and biased, optionally reduced to its absolute value, and saturated to the output width. The block sits between the line-buffer/window generator and the output formatter, and replaces the fixed 5×5 multiplier with a valid-qualified, stallable, runtime-scalable engine.

## Interface
- `K`, default 5: kernel edge; legal values 3, 5, 7.
- `INPUT_DATA_WIDTH`, default 8: signed pixel width.
- `CSC_WIDTH`, default 8: signed coefficient width.
- `BIAS_WIDTH`, default 8: signed bias width.
- `OUTPUT_DATA_WIDTH`, default 8: signed result width.
- `ACC_WIDTH`, default `INPUT_DATA_WIDTH+CSC_WIDTH+$clog2(K*K)`: accumulator width (derived; not overridden).
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rstn`, in, 1: reset. Asynchronous and active-low.
- `i_en`, in, 1: pipeline advance enable. Low means the whole pipeline stalls.
- `i_valid`, in, 1: the window, coefficients, bias, shift and mode on this cycle are a job.
- `i_coef`, in, `K*K*CSC_WIDTH`: flattened coefficients. Element (r,c) is at slice index r*K+c, with index 0 in the LSBs.
- `i_x`, in, `K*K*INPUT_DATA_WIDTH`: flattened pixel window. Same ordering as `i_coef`.
- `i_bias`, in, `BIAS_WIDTH`: signed bias, added after the shift.
- `i_shift`, in, 5: right-shift amount, 0..`ACC_WIDTH`-1.
- `i_abs`, in, 1: 1 selects absolute-value mode; 0 selects signed output.
- `o_valid`, out, 1: `o_y` holds a new result this cycle.
- `o_y`, out, `OUTPUT_DATA_WIDTH`: signed saturated result.

## Operation
- Four register stages, S1..S4. Each stage has a valid bit v1..v4. `i_coef`, `i_x`, `i_bias`, `i_shift` and `i_abs` are all sampled together into S1. Bias, shift and abs travel with their job, so configuration may change every cycle without corrupting in-flight jobs.
- S1: K×K signed products, each `INPUT_DATA_WIDTH+CSC_WIDTH` bits.
- S2: K row sums, each sign-extended to `ACC_WIDTH`.
- S3: acc = sum of the row sums. The stage then computes t = (acc + rnd) >>> shift as an arithmetic shift.
  - rnd = 2^(shift-1) when shift>0, else 0.
  - The addition is done in `ACC_WIDTH+1` bits. Rounding is round-half-up toward +inf.
- S4: y = t + sign-extended bias, computed in `ACC_WIDTH+2` bits.
  - If abs=1, y = |y|. Taking the width-extended |y| first prevents wrap on the most-negative value.
  - The result then saturates to [-2^(OUTPUT_DATA_WIDTH-1), 2^(OUTPUT_DATA_WIDTH-1)-1] and is registered into `o_y`.
- Stall: while `i_en`=0, every data register and v1..v4 hold their value and `i_valid` is ignored.
- `o_valid` = v4 AND `i_en`. Each result is therefore presented valid in exactly one cycle: the cycle in which it advances.
- Bubbles: a stage whose valid bit is 0 may still update its data registers. The downstream consumer uses only `o_valid`-qualified `o_y`.
- `i_shift` ≥ `ACC_WIDTH` is illegal. The result is undefined but must not hang the pipeline.

## Timing
- Reset (rstn=0, asynchronous): v1..v4=0, `o_valid`=0, `o_y`=0, all stage registers cleared. Reset mid-operation discards every in-flight job, and no stale result is emitted after release.
- First edge after release with `i_en`=1 and `i_valid`=1: the job enters S1.
- Latency: 4 enabled edges from input sample to `o_y`/`o_valid`. With `i_en` held high, a result sampled at edge n is visible after edge n+4.
- Throughput: one job per enabled cycle. Back-to-back `i_valid` gives back-to-back `o_valid` with no gaps.
- A stall of S cycles adds exactly S cycles of latency to every in-flight job. Job order and values are unchanged.
- `i_valid`=1 with `i_en`=0 is not a job. The source must hold the job until `i_en`=1.

## Test plan
Unless stated, K=5 with default widths and `i_en`=1.
- Identity kernel: coef(2,2)=1, all others 0; x(2,2)=37; shift=0, bias=0, abs=0 -> `o_y`=37 with `o_valid` exactly 4 cycles after `i_valid`.
- Saturation: all coef=127, all x=127 (acc=403225) -> `o_y`=127. All coef=127, all x=-128 -> `o_y`=-128.
- Rounding and bias: all coef=1, all x=3 (acc=75), shift=3, bias=-2 -> (75+4)>>3=9, 9-2=7 -> `o_y`=7. Same job with shift=1, bias=0 -> `o_y`=38.
- Abs mode: coef(2,2)=-1, x(2,2)=50, all others 0, abs=1 -> `o_y`=50. Same job with abs=0 -> `o_y`=-50.
- Streaming with stall: 10 back-to-back jobs with distinct identity values 1..10 and per-job shift/abs changes; drop `i_en` for 3 cycles after job 4 -> 10 `o_valid` pulses in order with values 1..10, and the last result arrives 3 cycles later than in the no-stall run.
- Reset mid-stream: assert rstn=0 asynchronously with 3 jobs in flight -> `o_valid`/`o_y` go to 0 immediately; no result from those jobs appears after release; a new job after release appears 4 cycles later. Repeat the identity and rounding scenarios with K=3 and K=7.

Source files
------------

// File: rtl/filter_mac_kxk.sv
// rtl/filter_mac_kxk.sv - four-stage stallable KxK signed convolution MAC with round, shift, bias, abs and saturate
module filter_mac_kxk #(
   parameter int K                 = 5,
   parameter int INPUT_DATA_WIDTH  = 8,
   parameter int CSC_WIDTH         = 8,
   parameter int BIAS_WIDTH        = 8,
   parameter int OUTPUT_DATA_WIDTH = 8,
   parameter int ACC_WIDTH         = INPUT_DATA_WIDTH + CSC_WIDTH + $clog2(K*K)
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                i_en,
   input  logic                                i_valid,
   input  logic [K*K*CSC_WIDTH-1:0]            i_coef,
   input  logic [K*K*INPUT_DATA_WIDTH-1:0]     i_x,
   input  logic [BIAS_WIDTH-1:0]               i_bias,
   input  logic [4:0]                          i_shift,
   input  logic                                i_abs,
   output logic                                o_valid,
   output logic [OUTPUT_DATA_WIDTH-1:0]        o_y
);

   localparam int NT = K * K;
   localparam int IW = INPUT_DATA_WIDTH;
   localparam int CW = CSC_WIDTH;
   localparam int PW = IW + CW;
   localparam int AW = ACC_WIDTH;
   localparam int OW = OUTPUT_DATA_WIDTH;
   localparam logic signed [AW+1:0] Y_MAX = (AW+2)'((2 ** (OW-1)) - 1);
   localparam logic signed [AW+1:0] Y_MIN = (AW+2)'(-(2 ** (OW-1)));

   logic                         v1, v2, v3, v4;
   logic signed [PW-1:0]         s1_prod [NT];
   logic signed [BIAS_WIDTH-1:0] s1_bias, s2_bias, s3_bias;
   logic [4:0]                   s1_shift, s2_shift;
   logic                         s1_abs, s2_abs, s3_abs;
   logic signed [AW-1:0]         s2_row [K];
   logic signed [AW:0]           s3_t;
   logic [OW-1:0]                y_q;

   logic signed [PW-1:0]         prod_c [NT];
   logic signed [AW-1:0]         row_c [K];
   logic signed [AW-1:0]         acc_c;
   logic signed [AW:0]           rnd_c, sum_c, t_c;
   logic signed [AW+1:0]         y_c, mag_c;
   logic [OW-1:0]                sat_c;

   always_comb begin
      for (int i = 0; i < NT; i++) begin
         prod_c[i] = PW'($signed(i_x[i*IW +: IW])) * PW'($signed(i_coef[i*CW +: CW]));
      end
   end

   always_comb begin
      for (int r = 0; r < K; r++) begin
         row_c[r] = '0;
         for (int c = 0; c < K; c++) begin
            row_c[r] = row_c[r] + AW'(s1_prod[r*K+c]);
         end
      end
   end

   // Half-LSB rounding constant is added one bit wider so it cannot wrap the accumulator.
   always_comb begin
      acc_c = '0;
      for (int r = 0; r < K; r++) begin
         acc_c = acc_c + s2_row[r];
      end
      rnd_c = (s2_shift == 5'd0) ? '0 : ((AW+1)'(1) <<< (s2_shift - 5'd1));
      sum_c = (AW+1)'(acc_c) + rnd_c;
      t_c   = sum_c >>> s2_shift;
   end

   always_comb begin
      y_c   = (AW+2)'(s3_t) + (AW+2)'(s3_bias);
      mag_c = (s3_abs && (y_c < 0)) ? -y_c : y_c;
      if (mag_c > Y_MAX) begin
         sat_c = Y_MAX[OW-1:0];
      end else if (mag_c < Y_MIN) begin
         sat_c = Y_MIN[OW-1:0];
      end else begin
         sat_c = mag_c[OW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         v4 <= 1'b0;
         for (int i = 0; i < NT; i++) s1_prod[i] <= '0;
         for (int r = 0; r < K; r++) s2_row[r] <= '0;
         s1_bias  <= '0;
         s2_bias  <= '0;
         s3_bias  <= '0;
         s1_shift <= '0;
         s2_shift <= '0;
         s1_abs   <= 1'b0;
         s2_abs   <= 1'b0;
         s3_abs   <= 1'b0;
         s3_t     <= '0;
         y_q      <= '0;
      end else if (i_en) begin
         v1 <= i_valid;
         v2 <= v1;
         v3 <= v2;
         v4 <= v3;
         for (int i = 0; i < NT; i++) s1_prod[i] <= prod_c[i];
         for (int r = 0; r < K; r++) s2_row[r] <= row_c[r];
         s1_bias  <= i_bias;
         s2_bias  <= s1_bias;
         s3_bias  <= s2_bias;
         s1_shift <= i_shift;
         s2_shift <= s1_shift;
         s1_abs   <= i_abs;
         s2_abs   <= s1_abs;
         s3_abs   <= s2_abs;
         s3_t     <= t_c;
         y_q      <= sat_c;
      end
   end

   // A result is only offered in the cycle it actually leaves the pipeline.
   assign o_valid = v4 & i_en;
   assign o_y     = y_q;

endmodule
